// File: rtl/alu_issue_stage.sv
// ALU issue stage: one-entry valid/ready skid register between decode and the ALU,
// with operand forwarding (enabled by ALU_ISSUE_FORWARD_EN), one-hot op decode and a stall counter.
module alu_issue_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1_addr,
    input  logic [4:0]       in_rs2_addr,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [WIDTH-1:0] in_rs2_data,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    input  logic [3:0]       in_alu_op,
    input  logic [4:0]       in_rd_addr,
    input  logic             in_rd_we,
    input  logic             flush,
    input  logic             ex_ready,
    input  logic             exmem_we,
    input  logic [4:0]       exmem_rd,
    input  logic [WIDTH-1:0] exmem_data,
    input  logic             memwb_we,
    input  logic [4:0]       memwb_rd,
    input  logic [WIDTH-1:0] memwb_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [13:0]      alu_sel,
    output logic [4:0]       out_rd_addr,
    output logic             out_rd_we,
    output logic             illegal_op,
    output logic [CNT_W-1:0] stall_cnt
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // the upstream side holds its payload stable until then, and flush kills the transfer.
    assign in_ready = !out_valid || ex_ready;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;
    logic [13:0]      dec_sel;
    logic             dec_ill;

`ifdef ALU_ISSUE_FORWARD_EN
    // The younger EX/MEM result wins over MEM/WB; x0 is never forwarded.
    function automatic logic [WIDTH-1:0] resolve(input logic [4:0]       addr,
                                                  input logic [WIDTH-1:0] rf_data);
        if (addr != 5'd0 && exmem_we && exmem_rd == addr)
            return exmem_data;
        else if (addr != 5'd0 && memwb_we && memwb_rd == addr)
            return memwb_data;
        else
            return rf_data;
    endfunction

    always_comb begin
        fwd_a = resolve(in_rs1_addr, in_rs1_data);
        fwd_b = resolve(in_rs2_addr, in_rs2_data);
    end
`else
    always_comb begin
        fwd_a = in_rs1_data;
        fwd_b = in_rs2_data;
    end

    logic unused_fwd;
    assign unused_fwd = ^{exmem_we, exmem_rd, exmem_data, memwb_we, memwb_rd, memwb_data,
                          in_rs1_addr, in_rs2_addr};
`endif

    always_comb begin
        dec_sel = '0;
        dec_ill = 1'b0;
        if (in_alu_op > 4'd13)
            dec_ill = 1'b1;
        else
            dec_sel = 14'(1) << in_alu_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            operand_a   <= '0;
            operand_b   <= '0;
            alu_sel     <= '0;
            out_rd_addr <= '0;
            out_rd_we   <= 1'b0;
            illegal_op  <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (out_valid && !ex_ready && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);

            // Flush beats capture, drain and hold.
            if (flush) begin
                out_valid <= 1'b0;
            end else if (in_valid && in_ready) begin
                out_valid   <= 1'b1;
                operand_a   <= fwd_a;
                operand_b   <= in_use_imm ? in_imm : fwd_b;
                alu_sel     <= dec_sel;
                out_rd_addr <= in_rd_addr;
                out_rd_we   <= in_rd_we;
                illegal_op  <= dec_ill;
            end else if (ex_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected transactions are queued at issue time and
// checked by a monitor when the stage hands them to the ALU; handshake, stall and reset checked inline.
module tb_alu_issue_stage;

    localparam int W  = 32;
    localparam int CW = 16;
    localparam int EW = 2 * W + 14 + 5 + 1 + 1;

`ifdef ALU_ISSUE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rs1_addr, in_rs2_addr;
    logic [W-1:0]  in_rs1_data, in_rs2_data, in_imm;
    logic          in_use_imm;
    logic [3:0]    in_alu_op;
    logic [4:0]    in_rd_addr;
    logic          in_rd_we;
    logic          flush;
    logic          ex_ready;
    logic          exmem_we, memwb_we;
    logic [4:0]    exmem_rd, memwb_rd;
    logic [W-1:0]  exmem_data, memwb_data;
    logic          out_valid;
    logic [W-1:0]  operand_a, operand_b;
    logic [13:0]   alu_sel;
    logic [4:0]    out_rd_addr;
    logic          out_rd_we;
    logic          illegal_op;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .flush(flush), .ex_ready(ex_ready),
        .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .operand_a(operand_a), .operand_b(operand_b),
        .alu_sel(alu_sel), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
        .illegal_op(illegal_op), .stall_cnt(stall_cnt)
    );

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp, mon_got;
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [EW-1:0] pk(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [13:0] sel, input logic [4:0] rd,
                                         input logic we, input logic ill);
        return {a, b, sel, rd, we, ill};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: a transaction leaves the stage on an edge with out_valid && ex_ready.
    always @(negedge clk) begin
        if (!rst && out_valid && ex_ready) begin
            n_cmp++;
            mon_got = pk(operand_a, operand_b, alu_sel, out_rd_addr, out_rd_we, illegal_op);
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL txn_unexpected: got %0h expected none", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_err++;
                    $display("FAIL txn: got a=%0h b=%0h sel=%0h rd=%0d we=%0b ill=%0b expected %0h",
                             operand_a, operand_b, alu_sel, out_rd_addr, out_rd_we, illegal_op,
                             mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] op, input logic [4:0] r1a, input logic [W-1:0] r1d,
                          input logic [4:0] r2a, input logic [W-1:0] r2d, input logic [W-1:0] imm,
                          input logic ui, input logic [4:0] rd, input logic we);
        in_alu_op   = op;
        in_rs1_addr = r1a;
        in_rs1_data = r1d;
        in_rs2_addr = r2a;
        in_rs2_data = r2d;
        in_imm      = imm;
        in_use_imm  = ui;
        in_rd_addr  = rd;
        in_rd_we    = we;
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [W-1:0] ed,
                           input logic mw, input logic [4:0] mrd, input logic [W-1:0] md);
        exmem_we   = ew;
        exmem_rd   = erd;
        exmem_data = ed;
        memwb_we   = mw;
        memwb_rd   = mrd;
        memwb_data = md;
    endtask

    // Offer one instruction for one cycle; it must be accepted on that edge.
    task automatic issue(input logic [EW-1:0] e);
        in_valid = 1'b1;
        @(negedge clk);
        check("in_ready_at_issue", 64'(in_ready), 64'd1);
        exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_operand_a"}, 64'(operand_a), 64'd0);
        check({tag, "_operand_b"}, 64'(operand_b), 64'd0);
        check({tag, "_alu_sel"}, 64'(alu_sel), 64'd0);
        check({tag, "_out_rd_addr"}, 64'(out_rd_addr), 64'd0);
        check({tag, "_out_rd_we"}, 64'(out_rd_we), 64'd0);
        check({tag, "_illegal_op"}, 64'(illegal_op), 64'd0);
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
        set_in(4'd0, 5'd0, '0, 5'd0, '0, '0, 1'b0, 5'd0, 1'b0);
        set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        tick();

        // Back-to-back stream with ex_ready high
        set_in(4'd0, 5'd1, 32'd5, 5'd2, 32'd7, '0, 1'b0, 5'd10, 1'b1);
        issue(pk(32'd5, 32'd7, 14'h0001, 5'd10, 1'b1, 1'b0));

        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        set_in(4'd7, 5'd3, 32'h11, 5'd0, 32'h22, '0, 1'b0, 5'd4, 1'b1);
        issue(pk(FWD ? 32'hAA : 32'h11, 32'h22, 14'(1 << 7), 5'd4, 1'b1, 1'b0));

        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd4, 32'hCC);
        set_in(4'd2, 5'd0, 32'h33, 5'd4, 32'h44, '0, 1'b0, 5'd5, 1'b1);
        issue(pk(32'h33, FWD ? 32'hCC : 32'h44, 14'(1 << 2), 5'd5, 1'b1, 1'b0));

        set_fwd(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, '0);
        set_in(4'd9, 5'd5, 32'h55, 5'd3, 32'h66, 32'h1234, 1'b1, 5'd6, 1'b0);
        issue(pk(32'h55, 32'h1234, 14'(1 << 9), 5'd6, 1'b0, 1'b0));

        set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        set_in(4'd13, 5'd1, 32'hF0, 5'd2, 32'h0F, '0, 1'b0, 5'd8, 1'b1);
        issue(pk(32'hF0, 32'h0F, 14'h2000, 5'd8, 1'b1, 1'b0));

        set_in(4'd15, 5'd1, 32'h1, 5'd2, 32'h2, '0, 1'b0, 5'd9, 1'b1);
        issue(pk(32'h1, 32'h2, 14'h0000, 5'd9, 1'b1, 1'b1));

        set_in(4'd14, 5'd1, 32'h3, 5'd2, 32'h4, '0, 1'b0, 5'd11, 1'b0);
        issue(pk(32'h3, 32'h4, 14'h0000, 5'd11, 1'b0, 1'b1));
        tick();

        // Stall: held for four stalled edges, then released
        set_in(4'd1, 5'd1, 32'd9, 5'd2, 32'd3, '0, 1'b0, 5'd7, 1'b1);
        ex_ready = 1'b0;
        issue(pk(32'd9, 32'd3, 14'h0002, 5'd7, 1'b1, 1'b0));
        repeat (4) begin
            @(negedge clk);
            check("stall_operand_a", 64'(operand_a), 64'd9);
            tick();
        end
        @(negedge clk);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_operand_b", 64'(operand_b), 64'd3);
        check("stall_alu_sel", 64'(alu_sel), 64'h0002);
        check("stall_cnt_4", 64'(stall_cnt), 64'd4);
        tick();
        ex_ready = 1'b1;
        tick();
        @(negedge clk);
        check("stall_cnt_after_release", 64'(stall_cnt), 64'd5);
        check("drained_out_valid", 64'(out_valid), 64'd0);
        tick();

        // Flush together with an accepted offer: nothing captured
        set_in(4'd6, 5'd1, 32'h77, 5'd2, 32'h88, '0, 1'b0, 5'd12, 1'b1);
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check("flush_capture_out_valid", 64'(out_valid), 64'd0);
        tick();

        // Flush kills a held instruction (the flush edge is also a stalled edge)
        ex_ready = 1'b0;
        set_in(4'd8, 5'd1, 32'h99, 5'd2, 32'h66, '0, 1'b0, 5'd13, 1'b1);
        issue(pk(32'h99, 32'h66, 14'(1 << 8), 5'd13, 1'b1, 1'b0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("flush_hold_out_valid", 64'(out_valid), 64'd0);
        check("stall_cnt_after_flush", 64'(stall_cnt), 64'd6);
        tick();

        // Saturation: stall from 6 up to FFFE, then three more edges
        set_in(4'd10, 5'd1, 32'h1357, 5'd2, 32'h2468, '0, 1'b0, 5'd14, 1'b1);
        issue(pk(32'h1357, 32'h2468, 14'(1 << 10), 5'd14, 1'b1, 1'b0));
        repeat (65528) tick();
        @(negedge clk);
        check("stall_cnt_fffe", 64'(stall_cnt), 64'hFFFE);
        repeat (3) tick();
        @(negedge clk);
        check("stall_cnt_sat", 64'(stall_cnt), 64'hFFFF);
        check("sat_operand_a", 64'(operand_a), 64'h1357);
        check("sat_out_valid", 64'(out_valid), 64'd1);
        tick();

        // Reset in the middle of the stall discards the held instruction
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_stall_reset");
        tick();

        ex_ready = 1'b1;
        set_in(4'd11, 5'd1, 32'h80000000, 5'd2, 32'h4, '0, 1'b0, 5'd15, 1'b1);
        issue(pk(32'h80000000, 32'h4, 14'(1 << 11), 5'd15, 1'b1, 1'b0));
        tick();
        tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the datapath width.
REQ-002 The block SHALL have parameter CNT_W, default 16, setting the stall counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: decode offers an instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the stage can accept an instruction.
REQ-007 The block SHALL have ports in_rs1_addr and in_rs2_addr, inputs, 5 bits each: source register indices.
REQ-008 The block SHALL have ports in_rs1_data and in_rs2_data, inputs, WIDTH bits each: register-file read data.
REQ-009 The block SHALL have ports in_imm (input, WIDTH bits) and in_use_imm (input, 1 bit): immediate operand and select.
REQ-010 The block SHALL have port in_alu_op, input, 4 bits: encoded operation, 0..13 = add, sub, mul, mulh, mulhsu, mulhu, and, or, xor, sll, srl, sra, slt, sltu.
REQ-011 The block SHALL have ports in_rd_addr (input, 5 bits) and in_rd_we (input, 1 bit): destination register and write enable.
REQ-012 The block SHALL have port flush, input, 1 bit: kill the held instruction.
REQ-013 The block SHALL have port ex_ready, input, 1 bit: the ALU stage consumes this cycle.
REQ-014 The block SHALL have ports exmem_we (1), exmem_rd (5) and exmem_data (WIDTH), inputs: EX/MEM forward source.
REQ-015 The block SHALL have ports memwb_we (1), memwb_rd (5) and memwb_data (WIDTH), inputs: MEM/WB forward source.
REQ-016 The block SHALL have port out_valid, output, 1 bit: the held instruction is valid.
REQ-017 The block SHALL have ports operand_a and operand_b, outputs, WIDTH bits each: registered ALU operands.
REQ-018 The block SHALL have port alu_sel, output, 14 bits: registered one-hot selects, bit i = op code i.
REQ-019 The block SHALL have ports out_rd_addr (5 bits), out_rd_we (1 bit) and illegal_op (1 bit), outputs.
REQ-020 The block SHALL have port stall_cnt, output, CNT_W bits: count of stalled cycles.

Function
REQ-021 The block SHALL drive in_ready = !out_valid || ex_ready, combinationally.
REQ-022 The block SHALL capture all inputs on the edge where in_valid && in_ready && !flush, giving a latency of 1 cycle to out_valid.
REQ-023 The block SHALL clear out_valid when ex_ready && out_valid && !(in_valid && in_ready) (drain).
REQ-024 The block SHALL hold operands, selects and out_valid unchanged while out_valid && !ex_ready.
REQ-025 The block SHALL clear out_valid on the next edge when flush=1, with priority over capture and hold in the same cycle.
REQ-026 The block SHALL resolve rs1 to exmem_data if exmem_we && exmem_rd==rs1 && rs1!=0; otherwise memwb_data under the same rule; otherwise in_rs1_data; rs2 follows the same rule.
REQ-027 The block SHALL never forward to x0: an rs index of 0 always resolves to in_rsN_data.
REQ-028 The block SHALL set operand_b to in_imm when in_use_imm=1, with no forwarding applied to operand_b in that case.
REQ-029 The block SHALL decode in_alu_op 14 or 15 to alu_sel=0 and illegal_op=1, and SHALL still register the instruction as valid.
REQ-030 The block SHALL increment stall_cnt each cycle out_valid && !ex_ready, saturating at all-ones with no wrap.

Reset
REQ-031 On an edge with rst=1, the block SHALL set out_valid=0, operand_a=0, operand_b=0, alu_sel=0, out_rd_addr=0, out_rd_we=0, illegal_op=0 and stall_cnt=0, overriding flush and capture.
REQ-032 The block SHALL drive in_ready=1 in the first cycle after reset, and a held instruction SHALL be discarded on reset.

Configuration
REQ-033 When ALU_ISSUE_FORWARD_EN is defined, the block SHALL implement REQ-026 in full.
REQ-034 When ALU_ISSUE_FORWARD_EN is undefined, the block SHALL ignore all exmem_* and memwb_* inputs and take operands directly from in_rs1_data and in_rs2_data.

Verification
REQ-035 The bench SHALL apply in_valid=1, alu_op=0, rs1_data=5, rs2_data=7, ex_ready=1 and check the next cycle for out_valid=1, operand_a=5, operand_b=7, alu_sel=14'h0001.
REQ-036 The bench SHALL set exmem_we=1, exmem_rd=3, exmem_data=0xAA, memwb_we=1, memwb_rd=3, memwb_data=0xBB, rs1=3, and check operand_a=0xAA; with rs1=0 and exmem_rd=0, operand_a SHALL equal in_rs1_data.
REQ-037 The bench SHALL hold ex_ready=0 for 4 cycles with out_valid=1 and check in_ready=0, operands stable and stall_cnt=4.
REQ-038 The bench SHALL assert flush and in_valid together with in_ready=1 and check out_valid=0 next cycle.
REQ-039 The bench SHALL apply alu_op=15 and check alu_sel=0, illegal_op=1 and out_valid=1.
REQ-040 The bench SHALL preload stall_cnt to 16'hFFFE and hold the stall 3 cycles, checking stall_cnt=16'hFFFF; then assert rst mid-stall and check all outputs are 0 on the next cycle.
